// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-fetch controller and its skid buffer.
package imem_pkg;

    localparam int          IMEM_ADDR_W   = 5;
    localparam int          IMEM_RESET_PC = 0;
    localparam logic [31:0] NOP_INSTR     = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer: captures an item when empty, releases it on out_ready.
module fetch_skid_buf #(
    parameter int PC_W = 5
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;

    // Producer only pushes while empty; a held entry stays put until released.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            if (out_ready) begin
                valid_d = 1'b0;
            end
        end else if (in_valid) begin
            valid_d = 1'b1;
            instr_d = in_instr;
            pc_d    = in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/imem_fetch_controller.sv
// Instruction fetch sequencer: issues one read per cycle, presents returned words with their PC,
// absorbs decode stalls with a one-entry skid buffer, redirects on branches, shares the port with a loader.
module imem_fetch_controller
    import imem_pkg::*;
#(
    parameter int ADDR_W   = IMEM_ADDR_W,
    parameter int RESET_PC = IMEM_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        LdWe,
    input  logic [31:0] LdAddr,
    input  logic [31:0] LdData,
    output logic        LdErr,
    output logic [31:0] MemAddr,
    output logic        MemRe,
    output logic        MemWe,
    output logic [31:0] MemWdata,
    input  logic [31:0] MemRdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] InstrPC
);

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic              skid_valid;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    logic              pres_valid;
    logic [31:0]       pres_instr;
    logic [ADDR_W-1:0] pres_pc;
    logic              issue;
    logic              pending_next;
    logic              ld_grant;
    logic              unused_addr_bits;

    // The skid entry is always older than any read arriving on MemRdata.
    assign pres_valid = skid_valid || inflight_q;
    assign pres_instr = skid_valid ? skid_instr : MemRdata;
    assign pres_pc    = skid_valid ? skid_pc : inflight_pc_q;

    // Holding off the read while Stall is high guarantees the single skid entry never overflows.
    assign issue        = (state_q == ST_RUN) && Run && !BranchTaken && !Stall;
    assign pending_next = (!BranchTaken && Stall && pres_valid) || issue;

    fetch_skid_buf #(
        .PC_W(ADDR_W)
    ) u_skid (
        .clk      (Clk),
        .srst     (Reset),
        .flush    (BranchTaken),
        .in_valid (inflight_q && Stall),
        .in_instr (MemRdata),
        .in_pc    (inflight_pc_q),
        .out_ready(!Stall),
        .out_valid(skid_valid),
        .out_instr(skid_instr),
        .out_pc   (skid_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = pc_q;
        case (state_q)
            ST_IDLE: begin
                pc_d = START_PC;
                if (Run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (BranchTaken) begin
                    pc_d = BranchTarget[ADDR_W-1:0];
                end else if (issue) begin
                    pc_d = pc_q + ADDR_W'(1);
                end
                if (!Run) begin
                    state_d = pending_next ? ST_DRAIN : ST_IDLE;
                    pc_d    = START_PC;
                end
            end
            ST_DRAIN: begin
                pc_d = START_PC;
                if (!pending_next) begin
                    state_d = Run ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = START_PC;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= START_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Fetch never reads while Run is low, so the loader can use the port without arbitration.
    assign ld_grant = LdWe && !Run;
    assign LdErr    = LdWe && Run;
    assign MemWe    = ld_grant;
    assign MemRe    = issue;
    assign MemWdata = ld_grant ? LdData : '0;
    assign MemAddr  = ld_grant ? 32'(LdAddr[ADDR_W-1:0]) :
                      issue    ? 32'(pc_q) : '0;

    assign InstrValid = pres_valid;
    assign Instr      = pres_valid ? pres_instr : NOP_INSTR;
    assign InstrPC    = pres_valid ? 32'(pres_pc) : '0;

    assign unused_addr_bits = ^{BranchTarget[31:ADDR_W], LdAddr[31:ADDR_W]};

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed bench for imem_fetch_controller with a registered-read 32-word memory model.
module tb_imem_fetch_controller;

    logic        Clk = 1'b0;
    logic        Reset, Run, Stall, BranchTaken, LdWe;
    logic [31:0] BranchTarget, LdAddr, LdData;
    logic        LdErr, MemRe, MemWe, InstrValid;
    logic [31:0] MemAddr, MemWdata, Instr, InstrPC;
    logic [31:0] MemRdata = 32'h0;
    logic [31:0] mem [32];

    int tests  = 0;
    int failed = 0;

    imem_fetch_controller dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .LdWe(LdWe), .LdAddr(LdAddr), .LdData(LdData), .LdErr(LdErr),
        .MemAddr(MemAddr), .MemRe(MemRe), .MemWe(MemWe), .MemWdata(MemWdata),
        .MemRdata(MemRdata), .Instr(Instr), .InstrValid(InstrValid), .InstrPC(InstrPC)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (MemWe) mem[MemAddr[4:0]] <= MemWdata;
        if (MemRe) MemRdata <= mem[MemAddr[4:0]];
    end

    typedef struct {
        logic        run, stall, br;
        logic [31:0] tgt;
        logic        ldwe;
        logic [31:0] ldaddr, lddata;
        logic        e_re;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_lderr, e_we;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] dword(input int p);
        return 32'hA000_0000 + 32'(p);
    endfunction

    function automatic vec_t mk(input bit run, input bit stall, input bit br, input logic [31:0] tgt,
                                input bit ldwe, input int ldaddr, input logic [31:0] lddata,
                                input bit e_re, input int e_addr, input bit e_valid, input int e_pc,
                                input bit e_lderr, input bit e_we);
        vec_t v;
        v.run = run; v.stall = stall; v.br = br; v.tgt = tgt;
        v.ldwe = ldwe; v.ldaddr = 32'(ldaddr); v.lddata = lddata;
        v.e_re = e_re; v.e_addr = 32'(e_addr); v.e_valid = e_valid; v.e_pc = 32'(e_pc);
        v.e_lderr = e_lderr; v.e_we = e_we;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Run = 0; Stall = 0; BranchTaken = 0; BranchTarget = 0;
        LdWe = 0; LdAddr = 0; LdData = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".InstrValid"}, 32'(InstrValid), 32'h0);
        chk({tag, ".Instr"}, Instr, 32'h0);
        chk({tag, ".InstrPC"}, InstrPC, 32'h0);
        chk({tag, ".MemRe"}, 32'(MemRe), 32'h0);
        chk({tag, ".MemWe"}, 32'(MemWe), 32'h0);
        chk({tag, ".MemAddr"}, MemAddr, 32'h0);
        chk({tag, ".MemWdata"}, MemWdata, 32'h0);
        chk({tag, ".LdErr"}, 32'(LdErr), 32'h0);
    endtask

    initial begin
        int lat;
        idle_inputs();
        Reset = 1;
        repeat (2) @(negedge Clk);
        Reset = 0;
        #1 chk_all_zero("reset");
        $display("[TB] reset released, outputs idle");

        // Loader fills all words; upper LdAddr bits must be dropped.
        for (int i = 0; i < 32; i++) begin
            @(negedge Clk);
            LdWe = 1; LdAddr = 32'h400 + 32'(i); LdData = dword(i);
            #1;
            chk("load.MemWe", 32'(MemWe), 32'h1);
            chk("load.MemAddr", MemAddr, 32'(i));
            chk("load.MemWdata", MemWdata, dword(i));
            chk("load.LdErr", 32'(LdErr), 32'h0);
            $display("[TB] load word %0d data=%h", i, dword(i));
        end
        @(negedge Clk);
        idle_inputs();

        //            run st br tgt           we ad dat            re ad va pc er we
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             0, 0, 0, 0, 0, 0)); // v0 IDLE->RUN
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 0, 0, 0, 0, 0)); // v1 first read
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 1, 1, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 2, 1, 1, 0, 0));
        vq.push_back(mk(1, 1, 0, 0,            0, 0, 0,             0, 0, 1, 2, 0, 0)); // v4 stall x3
        vq.push_back(mk(1, 1, 0, 0,            0, 0, 0,             0, 0, 1, 2, 0, 0));
        vq.push_back(mk(1, 1, 0, 0,            0, 0, 0,             0, 0, 1, 2, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 3, 1, 2, 0, 0)); // v7 release
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 4, 1, 3, 0, 0));
        vq.push_back(mk(1, 0, 1, 32'd20,       0, 0, 0,             0, 0, 1, 4, 0, 0)); // v9 branch
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 20, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 21, 1, 20, 0, 0));
        vq.push_back(mk(1, 1, 1, 32'hFFFFFFE8, 0, 0, 0,             0, 0, 1, 21, 0, 0)); // v12 br+stall
        vq.push_back(mk(1, 1, 0, 0,            0, 0, 0,             0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 8, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 9, 1, 8, 0, 0));
        vq.push_back(mk(1, 0, 1, 32'd30,       0, 0, 0,             0, 0, 1, 9, 0, 0)); // v16 to 30
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 30, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 31, 1, 30, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 0, 1, 31, 0, 0)); // wrap
        vq.push_back(mk(1, 0, 0, 0,            1, 3, 32'hDEADBEEF,  1, 1, 1, 0, 1, 0)); // v20 rejected
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 2, 1, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 3, 1, 2, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 4, 1, 3, 0, 0)); // word 3 intact
        vq.push_back(mk(0, 1, 0, 0,            0, 0, 0,             0, 0, 1, 4, 0, 0)); // v24 drain
        vq.push_back(mk(0, 1, 0, 0,            0, 0, 0,             0, 0, 1, 4, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,            0, 0, 0,             0, 0, 1, 4, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,            0, 0, 0,             0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,            1, 7, 32'hA0000007,  0, 7, 0, 0, 0, 1)); // idle write
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0,            0, 0, 0,             1, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 32'd9,        0, 0, 0,             0, 0, 1, 1, 0, 0)); // br + run fall
        vq.push_back(mk(0, 0, 0, 0,            0, 0, 0,             0, 0, 0, 0, 0, 0));

        foreach (vq[k]) begin
            @(negedge Clk);
            Run = vq[k].run; Stall = vq[k].stall; BranchTaken = vq[k].br; BranchTarget = vq[k].tgt;
            LdWe = vq[k].ldwe; LdAddr = vq[k].ldaddr; LdData = vq[k].lddata;
            #1;
            chk($sformatf("v%0d.MemRe", k), 32'(MemRe), 32'(vq[k].e_re));
            chk($sformatf("v%0d.MemAddr", k), MemAddr, vq[k].e_addr);
            chk($sformatf("v%0d.MemWe", k), 32'(MemWe), 32'(vq[k].e_we));
            chk($sformatf("v%0d.LdErr", k), 32'(LdErr), 32'(vq[k].e_lderr));
            chk($sformatf("v%0d.InstrValid", k), 32'(InstrValid), 32'(vq[k].e_valid));
            chk($sformatf("v%0d.InstrPC", k), InstrPC, vq[k].e_pc);
            chk($sformatf("v%0d.Instr", k), Instr, vq[k].e_valid ? dword(int'(vq[k].e_pc)) : 32'h0);
            $display("[TB] vec %0d run=%0b stall=%0b br=%0b re=%0b addr=%0d valid=%0b pc=%0d instr=%h",
                     k, Run, Stall, BranchTaken, MemRe, MemAddr, InstrValid, InstrPC, Instr);
        end

        // Reset while the skid buffer holds an entry.
        idle_inputs();
        Run = 1;
        repeat (3) @(negedge Clk);
        Stall = 1;
        #1;
        chk("skid.pre.InstrPC", InstrPC, 32'h1);
        @(negedge Clk);
        #1;
        chk("skid.full.InstrValid", 32'(InstrValid), 32'h1);
        chk("skid.full.InstrPC", InstrPC, 32'h1);
        chk("skid.full.MemRe", 32'(MemRe), 32'h0);
        $display("[TB] skid full at pc=%0d, asserting reset", InstrPC);
        Reset = 1;
        @(negedge Clk);
        Reset = 0; Stall = 0;
        #1 chk_all_zero("midreset");
        $display("[TB] mid-run reset cleared outputs");

        lat = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            #1;
            if (InstrValid) begin
                lat = c;
                break;
            end
        end
        chk("restart.latency", 32'(lat), 32'h1);
        chk("restart.InstrPC", InstrPC, 32'h0);
        chk("restart.Instr", Instr, dword(0));
        $display("[TB] restart first pc=%0d after %0d cycles", InstrPC, lat);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
